// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//
// Bundles everything that crosses the arbiter boundary apart from clock and
// reset: the two requester ports (sequencer = port 0, host = port 1) and the
// pins of the shared 32-word accumulation memory.
//
// Modports
//   slave  : the arbiter itself. Requester signals and mem_rdata are inputs;
//            grants, done pulses, rdata and memory strobes are outputs.
//   master : the environment, i.e. both requesters plus the memory. Every
//            direction is the mirror image of the slave modport.
//
// Signals
//   req0/1, valid0/1, wr0/1     requester controls
//   addr0/1, wdata0/1           requester address / write data
//   gnt0/1, done0/1             ownership and access-complete pulse
//   rdata                       last read result
//   mem_address, mem_wdata      memory address / write data
//   mem_read_enable,
//   mem_write_enable            memory strobes
//   mem_rdata                   memory read data
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
);
  logic                  req0;
  logic                  req1;
  logic                  valid0;
  logic                  valid1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic                  wr0;
  logic                  wr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  gnt0;
  logic                  gnt1;
  logic                  done0;
  logic                  done1;
  logic [DATA_WIDTH-1:0] rdata;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_read_enable;
  logic                  mem_write_enable;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req0, req1, valid0, valid1, addr0, addr1, wr0, wr1, wdata0, wdata1,
    input  mem_rdata,
    output gnt0, gnt1, done0, done1, rdata,
    output mem_address, mem_read_enable, mem_write_enable, mem_wdata
  );

  modport master (
    output req0, req1, valid0, valid1, addr0, addr1, wr0, wr1, wdata0, wdata1,
    output mem_rdata,
    input  gnt0, gnt1, done0, done1, rdata,
    input  mem_address, mem_read_enable, mem_write_enable, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port accumulation memory between the accumulation
// sequencer (port 0) and the host load/unload port (port 1). A requester
// locks the memory by holding req; while it owns the grant it issues single
// read/write accesses with valid and gets a one-cycle done pulse back. Each
// access drives the memory strobes for exactly two cycles. On release the
// round-robin pointer moves to the other port so neither side can starve.
//
// Ports
//   clock  : system clock, all state changes on the rising edge
//   reset  : synchronous, active-high
//   bus    : mem_arbiter_if.slave (requester ports + memory pins)
//
// All outputs are decoded from registered state only.
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic         clock,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_ACCESS,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  prio_q,  prio_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic                  wr_q,    wr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // Owner-selected view of the requester inputs. The non-owner's signals
  // never reach the state machine.
  logic                  own_req;
  logic                  own_valid;
  logic [ADDR_WIDTH-1:0] own_addr;
  logic                  own_wr;
  logic [DATA_WIDTH-1:0] own_wdata;

  always_comb begin
    own_req   = owner_q ? bus.req1   : bus.req0;
    own_valid = owner_q ? bus.valid1 : bus.valid0;
    own_addr  = owner_q ? bus.addr1  : bus.addr0;
    own_wr    = owner_q ? bus.wr1    : bus.wr0;
    own_wdata = owner_q ? bus.wdata1 : bus.wdata0;
  end

  // State register. Reset also clears the latched access so an access that
  // is cut short leaves no trace on the memory pins.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          // A lone requester wins outright; a tie goes to prio.
          owner_d = (bus.req0 && bus.req1) ? prio_q : bus.req1;
          state_d = S_GRANT;
        end
      end

      S_GRANT: begin
        // Release beats a coincident valid; that valid is dropped.
        if (!own_req) begin
          prio_d  = ~owner_q;
          state_d = S_IDLE;
        end else if (own_valid) begin
          addr_d  = own_addr;
          wr_d    = own_wr;
          wdata_d = own_wdata;
          state_d = S_ACCESS;
        end
      end

      S_ACCESS: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // Memory data is only guaranteed at the end of the second strobe
        // cycle, so the capture happens on leaving S_WAIT. Writes leave
        // rdata untouched.
        if (!wr_q) begin
          rdata_d = bus.mem_rdata;
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_GRANT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode. Ownership is shown in every state but S_IDLE, including
  // the access cycles after the owner has already dropped req.
  logic busy;
  logic mem_phase;
  logic in_done;

  always_comb begin
    busy      = (state_q != S_IDLE);
    mem_phase = (state_q == S_ACCESS) || (state_q == S_WAIT);
    in_done   = (state_q == S_DONE);

    bus.gnt0             = busy && !owner_q;
    bus.gnt1             = busy &&  owner_q;
    bus.done0            = in_done && !owner_q;
    bus.done1            = in_done &&  owner_q;
    bus.rdata            = rdata_q;
    bus.mem_address      = addr_q;
    bus.mem_wdata        = wdata_q;
    bus.mem_read_enable  = mem_phase && !wr_q;
    bus.mem_write_enable = mem_phase &&  wr_q;
  end

  // Structural guarantees of the decode above.
  a_gnt_onehot : assert property (@(posedge clock) disable iff (reset)
    !(bus.gnt0 && bus.gnt1));
  a_en_excl : assert property (@(posedge clock) disable iff (reset)
    !(bus.mem_read_enable && bus.mem_write_enable));

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Stimulus pushes each expected access (owner, type, address, data, issue
// edge, expected rdata) into a scoreboard queue; a monitor on the falling
// edge checks the memory strobes, the done pulse and rdata against the queue
// head. The reference is a transaction-level model: an array holding memory
// contents plus the round-robin pointer, updated per access / per release.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mem_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) bus ();

  mem_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model driven by the DUT strobes; data is only shown while a
  // read strobe is active.
  logic [7:0] phys    [32];
  logic [7:0] ref_mem [32];
  assign bus.mem_rdata = bus.mem_read_enable ? phys[bus.mem_address] : 8'hEE;
  always @(posedge clock) if (bus.mem_write_enable) phys[bus.mem_address] <= bus.mem_wdata;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         port;
    bit         wr;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         v;
  } sb_t;
  sb_t sb[$];

  int         ref_prio = 0;
  logic [7:0] ref_last = 8'h00;
  bit         skip_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    sb_t h;
    bit  in_win;
    bit  done_exp;
    logic [1:0] gnt;
    logic [1:0] dn;
    gnt      = {bus.gnt1, bus.gnt0};
    dn       = {bus.done1, bus.done0};
    in_win   = 1'b0;
    done_exp = 1'b0;
    chk("gnt_excl", {31'd0, gnt[0] & gnt[1]}, 32'd0);
    chk("en_excl", {31'd0, bus.mem_read_enable & bus.mem_write_enable}, 32'd0);
    if (sb.size() > 0) begin
      h = sb[0];
      if (cyc == h.v || cyc == h.v + 1) begin
        in_win = 1'b1;
        chk("rd_en", {31'd0, bus.mem_read_enable}, {31'd0, !h.wr});
        chk("wr_en", {31'd0, bus.mem_write_enable}, {31'd0, h.wr});
        chk("mem_addr", {27'd0, bus.mem_address}, {27'd0, h.addr});
        if (h.wr) chk("mem_wdata", {24'd0, bus.mem_wdata}, {24'd0, h.wdata});
        chk("gnt_owner", {30'd0, gnt}, h.port ? 32'd2 : 32'd1);
      end else if (cyc == h.v + 2) begin
        done_exp = 1'b1;
        chk("done", {30'd0, dn}, h.port ? 32'd2 : 32'd1);
        chk("rdata", {24'd0, bus.rdata}, {24'd0, h.rdata});
        chk("gnt_done", {30'd0, gnt}, h.port ? 32'd2 : 32'd1);
        void'(sb.pop_front());
      end else if (cyc > h.v + 2) begin
        total++;
        bad++;
        $display("FAIL done_missing: access issued at edge %0d not completed by cycle %0d", h.v, cyc);
        void'(sb.pop_front());
      end
    end
    if (!in_win && !skip_en)
      chk("en_idle", {30'd0, bus.mem_read_enable, bus.mem_write_enable}, 32'd0);
    if (!done_exp) chk("done_idle", {30'd0, dn}, 32'd0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int p, input bit v);
    if (p == 0) bus.req0 = v; else bus.req1 = v;
  endtask

  task automatic set_port(input int p, input bit vld, input bit wr,
                          input logic [4:0] a, input logic [7:0] d);
    if (p == 0) begin
      bus.valid0 = vld; bus.wr0 = wr; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.valid1 = vld; bus.wr1 = wr; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  function automatic logic [31:0] gnt_of(input int p);
    return {31'd0, (p == 0) ? bus.gnt0 : bus.gnt1};
  endfunction

  task automatic acquire(input bit r0, input bit r1, output int w);
    @(negedge clock);
    bus.req0 = r0;
    bus.req1 = r1;
    w = (r0 && r1) ? ref_prio : (r1 ? 1 : 0);
    @(negedge clock);
    chk("grant", {30'd0, bus.gnt1, bus.gnt0}, (w == 1) ? 32'd2 : 32'd1);
  endtask

  task automatic do_access(input int p, input bit wr, input logic [4:0] a,
                           input logic [7:0] d, input bit drop);
    sb_t e;
    int  v;
    @(negedge clock);
    set_port(p, 1'b1, wr, a, d);
    // Other port throws junk at the arbiter; it must be ignored.
    set_port(1 - p, 1'($urandom), 1'($urandom), 5'($urandom), 8'($urandom));
    v = cyc + 1;
    if (wr) ref_mem[a] = d;
    else    ref_last   = ref_mem[a];
    e.port = p; e.wr = wr; e.addr = a; e.wdata = d; e.rdata = ref_last; e.v = v;
    sb.push_back(e);
    @(negedge clock);
    set_port(0, 1'b0, 1'b0, 5'd0, 8'd0);
    set_port(1, 1'b0, 1'b0, 5'd0, 8'd0);
    if (drop) set_req(p, 1'b0);
    while (cyc < v + 3) @(negedge clock);
    chk("sb_drain", sb.size(), 32'd0);
  endtask

  task automatic release_port(input int p, input bit dropped);
    int o;
    bit oreq;
    o = 1 - p;
    if (dropped) chk("hold_after_drop", gnt_of(p), 32'd1);
    else begin
      @(negedge clock);
      set_req(p, 1'b0);
    end
    @(negedge clock);
    chk("release", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
    ref_prio = o;
    oreq = (o == 0) ? bus.req0 : bus.req1;
    if (oreq) begin
      @(negedge clock);
      chk("handover", {30'd0, bus.gnt1, bus.gnt0}, (o == 1) ? 32'd2 : 32'd1);
    end
  endtask

  task automatic rand_accesses(input int p, output bit dl);
    int n;
    n  = $urandom_range(1, 3);
    dl = ($urandom_range(0, 3) == 0);
    for (int i = 0; i < n; i++)
      do_access(p, 1'($urandom), 5'($urandom), 8'($urandom), dl && (i == n - 1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w;
    int pat;
    bit dl;
    logic [4:0] ab;
    logic [7:0] db;

    for (int i = 0; i < 32; i++) begin
      phys[i]    = 8'($urandom);
      ref_mem[i] = phys[i];
    end
    phys[6] = 8'h2A; ref_mem[6] = 8'h2A;
    reset = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    set_port(0, 1'b0, 1'b0, 5'd0, 8'd0);
    set_port(1, 1'b0, 1'b0, 5'd0, 8'd0);

    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("reset_outs", {bus.gnt0, bus.gnt1, bus.done0, bus.done1,
                         bus.mem_read_enable, bus.mem_write_enable,
                         bus.mem_address, bus.mem_wdata, bus.rdata}, 32'd0);
    end

    // Simultaneous requests right after reset: port 0 favoured.
    acquire(1'b1, 1'b1, w);
    chk("first_tie_port0", w, 32'd0);
    release_port(0, 1'b0);
    release_port(1, 1'b0);

    // Single read of address 6.
    acquire(1'b1, 1'b0, w);
    do_access(0, 1'b0, 5'd6, 8'd0, 1'b0);
    chk("rd6", {24'd0, bus.rdata}, 32'h2A);
    release_port(0, 1'b0);

    // Port 1 writes 0x55 to 31, port 0 reads it back.
    acquire(1'b0, 1'b1, w);
    do_access(1, 1'b1, 5'd31, 8'h55, 1'b0);
    chk("wr_keeps_rdata", {24'd0, bus.rdata}, 32'h2A);
    release_port(1, 1'b0);
    acquire(1'b1, 1'b0, w);
    do_access(0, 1'b0, 5'd31, 8'd0, 1'b0);
    chk("rd31", {24'd0, bus.rdata}, 32'h55);
    release_port(0, 1'b0);

    // Burst of 8 reads while port 1 waits.
    acquire(1'b1, 1'b0, w);
    @(negedge clock);
    bus.req1 = 1'b1;
    for (int a = 0; a < 8; a++) begin
      do_access(0, 1'b0, 5'(a), 8'd0, 1'b0);
      chk("burst_gnt1_low", {31'd0, bus.gnt1}, 32'd0);
    end
    release_port(0, 1'b0);
    release_port(1, 1'b0);

    // Randomized sessions.
    for (int s = 0; s < 24; s++) begin
      pat = $urandom_range(1, 3);
      acquire(pat[0], pat[1], w);
      rand_accesses(w, dl);
      release_port(w, dl);
      if (pat == 3) begin
        rand_accesses(1 - w, dl);
        release_port(1 - w, dl);
      end
    end

    // Reset during S_WAIT of a write.
    acquire(1'b0, 1'b1, w);
    ab = 5'($urandom);
    db = 8'($urandom);
    @(negedge clock);
    skip_en = 1'b1;
    set_port(1, 1'b1, 1'b1, ab, db);
    ref_mem[ab] = db;
    @(negedge clock);
    set_port(1, 1'b0, 1'b0, 5'd0, 8'd0);
    chk("abort_we_on", {31'd0, bus.mem_write_enable}, 32'd1);
    @(negedge clock);
    reset = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clock);
    chk("abort_outs", {26'd0, bus.gnt0, bus.gnt1, bus.done0, bus.done1,
                       bus.mem_read_enable, bus.mem_write_enable}, 32'd0);
    ref_prio = 0;
    ref_last = 8'h00;
    reset = 1'b0;
    skip_en = 1'b0;
    @(negedge clock);
    chk("post_reset_outs", {bus.gnt0, bus.gnt1, bus.done0, bus.done1,
                            bus.mem_read_enable, bus.mem_write_enable,
                            bus.mem_address, bus.mem_wdata, bus.rdata}, 32'd0);
    acquire(1'b1, 1'b1, w);
    chk("prio_after_reset", w, 32'd0);
    do_access(0, 1'b0, ab, 8'd0, 1'b0);
    release_port(0, 1'b0);
    release_port(1, 1'b0);

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
